// File: rtl/axi_frame_reader_if.sv
// rtl/axi_frame_reader_if.sv - AXI4 read channels and pixel stream bundle for axi_frame_reader
interface axi_frame_reader_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]   M_AXI_ARID;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]            M_AXI_ARLEN;
    logic [2:0]            M_AXI_ARSIZE;
    logic [1:0]            M_AXI_ARBURST;
    logic                  M_AXI_ARLOCK;
    logic [3:0]            M_AXI_ARCACHE;
    logic [2:0]            M_AXI_ARPROT;
    logic [3:0]            M_AXI_ARQOS;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [ID_WIDTH-1:0]   M_AXI_RID;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RLAST;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;
    logic [23:0]           vid_data;
    logic                  vid_valid;
    logic                  vid_ready;
    logic                  vid_sof;
    logic                  vid_eol;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY, vid_data, vid_valid, vid_sof, vid_eol,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID, vid_ready
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY, vid_data, vid_valid, vid_sof, vid_eol,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID, vid_ready
    );
endinterface

// File: rtl/axi_frame_reader.sv
// rtl/axi_frame_reader.sv - AXI4 frame read master with credit-based burst issue, beat FIFO and pixel unpacker
// Optional RLAST checking: define FRAME_READER_RLAST_CHECK_EN.
module axi_frame_reader #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter int          C_M_AXI_BURST_LEN          = 32,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 128,
    parameter int          IMG_HDISP                  = 1920,
    parameter int          IMG_VDISP                  = 1080,
    parameter int          FIFO_DEPTH                 = 256
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                frame_start,
    output logic                busy,
    output logic                rresp_err,
    axi_frame_reader_if.master  m
);
    localparam int BL          = C_M_AXI_BURST_LEN;
    localparam int DW          = C_M_AXI_DATA_WIDTH;
    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int PPB         = DW / 32;
    localparam int TOTAL_BEATS = IMG_HDISP * IMG_VDISP / PPB;
    localparam int NBURSTS     = TOTAL_BEATS / BL;
    localparam int BURST_BYTES = BL * DW / 8;
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int CW          = $clog2(FIFO_DEPTH + 1);
    localparam int BW          = $clog2(NBURSTS + 1);
    localparam int XW          = $clog2(IMG_HDISP + 1);
    localparam int YW          = $clog2(IMG_VDISP + 1);
    localparam int IW          = (PPB > 1) ? $clog2(PPB) : 1;

    if ((DW % 32) != 0 || ((IMG_HDISP * IMG_VDISP) % PPB) != 0 || (TOTAL_BEATS % BL) != 0 ||
        BL < 1 || BL > 256 || FIFO_DEPTH < 2 * BL) begin : g_cfg_err
        $error("axi_frame_reader: invalid parameter combination");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   pix_q, pix_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            vid_valid_q, vid_valid_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic            ar_hs, r_hs, pix_hs, last_pix, pop, credit_ok;
`ifdef FRAME_READER_RLAST_CHECK_EN
    localparam int LW = $clog2(BL + 1);
    logic [LW-1:0]   beat_q, beat_d;
`endif

    always_comb begin
        ar_hs    = arvalid_q & m.M_AXI_ARREADY;
        r_hs     = rready_q & m.M_AXI_RVALID;
        pix_hs   = vid_valid_q & m.vid_ready;
        last_pix = pix_hs && (x_q == XW'(IMG_HDISP - 1)) && (y_q == YW'(IMG_VDISP - 1));
        // Pop as soon as the shift register is empty or its last pixel is leaving: no bubble between beats
        pop      = (fifo_cnt_q != '0) && (!vid_valid_q || (pix_hs && idx_q == IW'(PPB - 1)));

        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        araddr_d    = araddr_q;
        busy_d      = busy_q;
        err_d       = err_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        idx_d       = idx_q;
        vid_valid_d = vid_valid_q;

        fifo_cnt_d = fifo_cnt_q + (r_hs ? CW'(1) : '0) - (pop ? CW'(1) : '0);
        out_d      = out_q - (r_hs ? CW'(1) : '0) + (ar_hs ? CW'(BL) : '0);
        wr_ptr_d   = !r_hs ? wr_ptr_q : (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d   = !pop  ? rd_ptr_q : (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

        case (state_q)
            ST_IDLE: if (frame_start) begin
                state_d     = ST_ISSUE;
                busy_d      = 1'b1;
                err_d       = 1'b0;
                burst_cnt_d = '0;
                araddr_d    = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
                x_d         = '0;
                y_d         = '0;
            end
            ST_ISSUE: if (ar_hs) begin
                burst_cnt_d = burst_cnt_q + BW'(1);
                araddr_d    = araddr_q + AW'(BURST_BYTES);
                if (burst_cnt_q == BW'(NBURSTS - 1)) state_d = ST_DRAIN;
            end
            default: ;
        endcase
        if (last_pix) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end

        if (r_hs && m.M_AXI_RRESP != 2'b00) err_d = 1'b1;
`ifdef FRAME_READER_RLAST_CHECK_EN
        beat_d = beat_q;
        if (state_q == ST_IDLE && frame_start) beat_d = '0;
        if (r_hs) begin
            if (m.M_AXI_RLAST != (beat_q == LW'(BL - 1))) err_d = 1'b1;
            beat_d = (beat_q == LW'(BL - 1)) ? '0 : beat_q + LW'(1);
        end
`endif

        // Credit uses next-cycle occupancy; the sum can only shrink while ARVALID waits
        credit_ok = (32'(fifo_cnt_d) + 32'(out_d) + 32'(BL)) <= 32'(FIFO_DEPTH);
        if (arvalid_q && !m.M_AXI_ARREADY) arvalid_d = 1'b1;
        else                               arvalid_d = (state_d == ST_ISSUE) && credit_ok;
        rready_d = (state_d != ST_IDLE);

        if (pix_hs) begin
            pix_d = pix_q >> 32;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(PPB - 1)) vid_valid_d = 1'b0;
            if (x_q == XW'(IMG_HDISP - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_VDISP - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        if (pop) begin
            pix_d       = fifo_mem[rd_ptr_q];
            idx_d       = '0;
            vid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            araddr_q    <= AW'(C_M_TARGET_SLAVE_BASE_ADDR);
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            out_q       <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pix_q       <= '0;
            idx_q       <= '0;
            vid_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef FRAME_READER_RLAST_CHECK_EN
            beat_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            out_q       <= out_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pix_q       <= pix_d;
            idx_q       <= idx_d;
            vid_valid_q <= vid_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef FRAME_READER_RLAST_CHECK_EN
            beat_q      <= beat_d;
`endif
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (r_hs) fifo_mem[wr_ptr_q] <= m.M_AXI_RDATA;
    end

    assign m.M_AXI_ARID    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m.M_AXI_ARADDR  = araddr_q;
    assign m.M_AXI_ARLEN   = 8'(BL - 1);
    assign m.M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign m.M_AXI_ARBURST = 2'b01;
    assign m.M_AXI_ARLOCK  = 1'b0;
    assign m.M_AXI_ARCACHE = 4'b0010;
    assign m.M_AXI_ARPROT  = 3'b000;
    assign m.M_AXI_ARQOS   = 4'b0000;
    assign m.M_AXI_ARVALID = arvalid_q;
    assign m.M_AXI_RREADY  = rready_q;
    assign m.vid_data      = pix_q[23:0];
    assign m.vid_valid     = vid_valid_q;
    assign m.vid_sof       = vid_valid_q && (x_q == '0) && (y_q == '0);
    assign m.vid_eol       = vid_valid_q && (x_q == XW'(IMG_HDISP - 1));
    assign busy            = busy_q;
    assign rresp_err       = err_q;

    logic unused_sig;
`ifdef FRAME_READER_RLAST_CHECK_EN
    assign unused_sig = ^{m.M_AXI_RID, pix_q[31:24]};
`else
    assign unused_sig = ^{m.M_AXI_RID, pix_q[31:24], m.M_AXI_RLAST};
`endif
endmodule

// File: doc/axi_frame_reader.md
# axi_frame_reader

AXI4-Full read master that fetches one packed 24-bit RGB frame from the stitching frame buffer in memory and replays it as a pixel stream with valid/ready handshake and frame/line markers. It is the read-side counterpart of the camera-to-AXI write path: it sits between the shared AXI memory and the display/output pipeline. Each `frame_start` pulse produces exactly one frame, using credit-based burst issue into an internal beat FIFO.

## Interface
- `C_M_TARGET_SLAVE_BASE_ADDR`, default 32'h10000000: byte address of pixel (0,0).
- `C_M_AXI_BURST_LEN`, default 32: beats per burst; allowed values 1–256.
- `C_M_AXI_ID_WIDTH`, default 1: ARID/RID width.
- `C_M_AXI_ADDR_WIDTH`, default 32: address width.
- `C_M_AXI_DATA_WIDTH`, default 128: data width; must be a multiple of 32.
- `IMG_HDISP`, default 1920: pixels per line.
- `IMG_VDISP`, default 1080: lines per frame.
- `FIFO_DEPTH`, default 256: beat FIFO depth; must be ≥ 2×BURST_LEN.
- `M_AXI_ACLK` in 1: single clock.
- `M_AXI_ARESETN` in 1: asynchronous active-low reset.
- `frame_start` in 1: one-cycle request to read one frame; ignored while `busy`.
- `busy` out 1: high from the accepted `frame_start` until the last pixel has been accepted.
- `rresp_err` out 1: sticky flag; any RRESP≠0, plus RLAST faults when RLAST checking is compiled in (see Configuration); cleared by an accepted `frame_start`.
- `M_AXI_ARID` out ID_WIDTH: constant 0.
- `M_AXI_ARADDR` out ADDR_WIDTH: burst start byte address.
- `M_AXI_ARLEN` out 8: BURST_LEN−1.
- `M_AXI_ARSIZE` out 3: log2(DATA_WIDTH/8).
- `M_AXI_ARBURST` out 2: 2'b01 (INCR).
- `M_AXI_ARLOCK` out 1: 0.
- `M_AXI_ARCACHE` out 4: 4'b0010.
- `M_AXI_ARPROT` out 3: 0.
- `M_AXI_ARQOS` out 4: 0.
- `M_AXI_ARVALID` out 1 / `M_AXI_ARREADY` in 1: read address handshake.
- `M_AXI_RID` in ID_WIDTH: ignored.
- `M_AXI_RDATA` in DATA_WIDTH: read data.
- `M_AXI_RRESP` in 2: read response.
- `M_AXI_RLAST` in 1: last beat of burst.
- `M_AXI_RVALID` in 1 / `M_AXI_RREADY` out 1: read data handshake.
- `vid_data` out 24: RGB pixel.
- `vid_valid` out 1 / `vid_ready` in 1: pixel handshake.
- `vid_sof` out 1: qualifies pixel (0,0).
- `vid_eol` out 1: qualifies pixel x = HDISP−1.

## Operation
- PPB = DATA_WIDTH/32 pixels per beat; pixel k of a beat is in RDATA[32k+23:32k]; bits [32k+31:32k+24] are ignored.
- TOTAL_BEATS = HDISP·VDISP/PPB; NBURSTS = TOTAL_BEATS/BURST_LEN. Both divisions must be exact; this is checked at elaboration.
- Burst n address = BASE + n·BURST_LEN·DATA_WIDTH/8. Addresses are linear; no 4 KB split is performed.
- AR FSM:
  - IDLE: on `frame_start`, clear the burst counter and `rresp_err`, go to ISSUE.
  - ISSUE: assert ARVALID only when FIFO_DEPTH − (fifo_count + outstanding_beats) ≥ BURST_LEN. On ARREADY, add BURST_LEN to `outstanding_beats` and advance the address. After the last burst, go to DRAIN.
  - DRAIN: wait until the last pixel handshake completes, then return to IDLE.
- `outstanding_beats` is decremented on each R handshake. A simultaneous AR and R handshake applies both terms in the same cycle.
- RREADY = 1 whenever state ≠ IDLE. The credit rule guarantees the FIFO never overflows. An R beat arriving in IDLE is not accepted.
- Unpacker: pops one FIFO beat into a PPB-pixel shift register and emits pixels 0..PPB−1 in order, one per `vid_valid & vid_ready`. The next beat is popped when the last pixel of the current beat is accepted, so throughput is 1 pixel/cycle with no bubble.
- x/y counters advance on each pixel handshake. x wraps at HDISP−1. After the pixel at (HDISP−1, VDISP−1), `busy` drops the following cycle.

## Timing
- Reset values: ARVALID, RREADY, `vid_valid`, `vid_sof`, `vid_eol`, `busy`, `rresp_err` = 0; ARADDR = BASE; FIFO empty; FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately. Outstanding R beats after reset release are dropped because RREADY stays 0 in IDLE.
- `busy` and the first ARVALID rise in the cycle after `frame_start`.
- ARVALID/ARADDR stay stable until ARREADY; ARVALID never drops without a handshake.
- First `vid_valid` rises 2 cycles after the first R handshake: one cycle for the FIFO write, one for the unpack load.
- `vid_data`, `vid_sof` and `vid_eol` stay stable while `vid_valid & !vid_ready`.

## Configuration
- `FRAME_READER_RLAST_CHECK_EN` defined:
  - a per-burst beat counter compares RLAST with the count;
  - RLAST missing on beat BURST_LEN−1, or present on any other beat, sets `rresp_err`;
  - data is still consumed normally.
- `FRAME_READER_RLAST_CHECK_EN` undefined: RLAST is ignored and the beat counter is not built.

## Test plan
Unless noted, parameters are HDISP=8, VDISP=2, BURST_LEN=2, DATA=128, BASE=0x10000000.
- Basic frame, memory word i = {4 pixels i·4..i·4+3}: expect 2 bursts at 0x10000000 and 0x10000020, ARLEN=1, 16 pixels in order; `vid_sof` on pixel 0; `vid_eol` on pixels 7 and 15; `busy` low one cycle after pixel 15.
- `vid_ready` random 30% duty: identical pixel sequence; outputs stable while stalled.
- FIFO_DEPTH=4 with `vid_ready`=0 for 100 cycles: at most 2 bursts issued and ARVALID held low; issue resumes after pixels drain.
- RRESP=2'b10 on beat 3: `rresp_err` = 1 and stays 1 to frame end; the next `frame_start` clears it; the frame still completes.
- `frame_start` pulsed mid-frame: ignored, burst count stays 2. Reset asserted mid-frame: all outputs return to reset values, and a new `frame_start` yields a correct frame.
- With `FRAME_READER_RLAST_CHECK_EN` defined, slave asserts RLAST on beat 0 of a burst: `rresp_err` = 1.
